// File: rtl/cgia_pkg.sv
// Shared types and constants for the CGIA scanline read path.
package cgia_pkg;

  localparam int unsigned LB_AW_DEF = 8;
  localparam int unsigned DW_DEF    = 16;

  // Depth encodings carried on bpp_i.
  localparam logic [1:0] BPP_1 = 2'b00;
  localparam logic [1:0] BPP_2 = 2'b01;
  localparam logic [1:0] BPP_4 = 2'b10;
  localparam logic [1:0] BPP_8 = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StPrime,
    StFill0,
    StFill1,
    StActive,
    StDone
  } shift_state_e;

  // Index of the last pixel in a 16-bit word at the given depth (16/bpp - 1).
  function automatic logic [3:0] px_last(input logic [1:0] bpp);
    logic [3:0] r;
    unique case (bpp)
      BPP_1:   r = 4'd15;
      BPP_2:   r = 4'd7;
      BPP_4:   r = 4'd3;
      default: r = 4'd1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/linebuf_ram.sv
// Simple dual-port line buffer: one write port, one registered read port, no content reset.
module linebuf_ram #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 16
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] wadr_i,
  input  logic [DW-1:0] wdat_i,
  input  logic [AW-1:0] radr_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] mem [0:(1 << AW) - 1];

  // Write on strobe; read data appears the cycle after the address is presented.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[wadr_i] <= wdat_i;
    end
    q_o <= mem[radr_i];
  end

endmodule

// File: rtl/line_shifter.sv
// Scanline read side: double-banked line buffer plus word-to-pixel serializer.
module line_shifter
  import cgia_pkg::*;
#(
  parameter int unsigned LB_AW = LB_AW_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             hsync_i,
  input  logic             vsync_i,
  input  logic             hden_i,
  input  logic             den_i,
  input  logic [LB_AW:0]   line_len_i,
  input  logic [1:0]       bpp_i,
  input  logic             s_we_i,
  input  logic [LB_AW-1:0] s_adr_i,
  input  logic [DW-1:0]    s_dat_i,
  output logic [7:0]       pixel_o,
  output logic             de_o
);

  localparam logic [LB_AW:0] MaxLen = {1'b1, {LB_AW{1'b0}}};

  shift_state_e     state_q, state_d;
  logic             hsync_q;
  logic             rd_bank_q, rd_bank_d;
  logic [LB_AW-1:0] rd_adr_q, rd_adr_d;
  logic [LB_AW:0]   words_left_q, words_left_d;
  logic [DW-1:0]    sr_q, sr_d;
  logic [DW-1:0]    nxt_q, nxt_d;
  logic             nxt_valid_q, nxt_valid_d;
  logic [3:0]       pix_cnt_q, pix_cnt_d;
  logic [1:0]       bpp_q, bpp_d;
  logic [7:0]       pixel_q, pixel_d;
  logic             de_q, de_d;

  logic             hs_edge;
  logic [LB_AW:0]   len_clamped;
  logic [DW-1:0]    ram_q;
  logic [4:0]       shamt;
  logic [7:0]       top_pix;

  assign hs_edge     = hsync_i & ~hsync_q;
  assign len_clamped = (line_len_i > MaxLen) ? MaxLen : line_len_i;
  assign shamt       = 5'd1 << bpp_q;

  // Fetcher always writes the bank not being displayed. The read port is fed the
  // next-state address so ram_q tracks rd_adr_q with the RAM latency hidden.
  linebuf_ram #(
    .AW (LB_AW + 1),
    .DW (DW)
  ) u_linebuf_ram (
    .clk_i  (clk_i),
    .we_i   (s_we_i),
    .wadr_i ({~rd_bank_q, s_adr_i}),
    .wdat_i (s_dat_i),
    .radr_i ({rd_bank_d, rd_adr_d}),
    .q_o    (ram_q)
  );

  // Select the top bpp bits of the shift register, zero-extended.
  always_comb begin
    top_pix = 8'd0;
    unique case (bpp_q)
      BPP_1:   top_pix = {7'd0, sr_q[DW-1]};
      BPP_2:   top_pix = {6'd0, sr_q[DW-1 -: 2]};
      BPP_4:   top_pix = {4'd0, sr_q[DW-1 -: 4]};
      default: top_pix = sr_q[DW-1 -: 8];
    endcase
  end

  // Next-state: vsync beats hsync edge, which beats normal sequencing.
  always_comb begin
    state_d      = state_q;
    rd_bank_d    = rd_bank_q;
    rd_adr_d     = rd_adr_q;
    words_left_d = words_left_q;
    sr_d         = sr_q;
    nxt_d        = nxt_q;
    nxt_valid_d  = nxt_valid_q;
    pix_cnt_d    = pix_cnt_q;
    bpp_d        = bpp_q;
    pixel_d      = 8'd0;
    de_d         = 1'b0;

    if (vsync_i) begin
      state_d = StIdle;
    end else if (hs_edge) begin
      rd_bank_d    = ~rd_bank_q;
      rd_adr_d     = '0;
      words_left_d = len_clamped;
      nxt_valid_d  = 1'b0;
      state_d      = (den_i && (len_clamped != '0)) ? StPrime : StDone;
    end else begin
      unique case (state_q)
        StPrime: state_d = StFill0;
        StFill0: begin
          sr_d      = ram_q;
          bpp_d     = bpp_i;
          pix_cnt_d = px_last(bpp_i);
          rd_adr_d  = rd_adr_q + 1'b1;
          state_d   = StFill1;
        end
        StFill1: begin
          nxt_d       = ram_q;
          nxt_valid_d = (words_left_q > 1);
          state_d     = StActive;
        end
        StActive: begin
          if (hden_i) begin
            pixel_d = top_pix;
            de_d    = 1'b1;
            if (pix_cnt_q == 4'd0) begin
              words_left_d = words_left_q - 1'b1;
              if (!nxt_valid_q) begin
                state_d = StDone;
              end else begin
                sr_d        = nxt_q;
                pix_cnt_d   = px_last(bpp_q);
                rd_adr_d    = rd_adr_q + 1'b1;
                nxt_valid_d = (words_left_q > 2);
              end
            end else begin
              sr_d      = sr_q << shamt;
              pix_cnt_d = pix_cnt_q - 1'b1;
              nxt_d     = ram_q;
            end
          end else begin
            nxt_d = ram_q;
          end
        end
        default: ;
      endcase
    end
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      hsync_q      <= 1'b0;
      rd_bank_q    <= 1'b0;
      rd_adr_q     <= '0;
      words_left_q <= '0;
      sr_q         <= '0;
      nxt_q        <= '0;
      nxt_valid_q  <= 1'b0;
      pix_cnt_q    <= 4'd0;
      bpp_q        <= BPP_1;
      pixel_q      <= 8'd0;
      de_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      hsync_q      <= hsync_i;
      rd_bank_q    <= rd_bank_d;
      rd_adr_q     <= rd_adr_d;
      words_left_q <= words_left_d;
      sr_q         <= sr_d;
      nxt_q        <= nxt_d;
      nxt_valid_q  <= nxt_valid_d;
      pix_cnt_q    <= pix_cnt_d;
      bpp_q        <= bpp_d;
      pixel_q      <= pixel_d;
      de_q         <= de_d;
    end
  end

  assign pixel_o = pixel_q;
  assign de_o    = de_q;

endmodule

// File: tb/tb_line_shifter.sv
// Bench for line_shifter: per-line pixel-queue model plus directed literal checks.
`timescale 1ns/1ps
module tb_line_shifter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hsync = 1'b0, vsync = 1'b0, hden = 1'b0, den = 1'b0;
  logic [8:0] line_len = '0;
  logic [1:0] bpp = '0;
  logic       s_we = 1'b0;
  logic [7:0] s_adr = '0;
  logic [15:0] s_dat = '0;
  logic [7:0] pixel;
  logic       de;

  always #5 clk = ~clk;

  line_shifter dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .hsync_i    (hsync),
    .vsync_i    (vsync),
    .hden_i     (hden),
    .den_i      (den),
    .line_len_i (line_len),
    .bpp_i      (bpp),
    .s_we_i     (s_we),
    .s_adr_i    (s_adr),
    .s_dat_i    (s_dat),
    .pixel_o    (pixel),
    .de_o       (de)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int cyc = 0;
  int cap[$];
  int cap_cyc[$];

  // Model: a line becomes a queue of pixels at the hsync edge; after three setup
  // cycles one pixel is popped per hden cycle until the queue runs dry.
  logic [15:0] mdl_mem [512];
  bit          mdl_bank = 1'b0;
  bit          mdl_hs_q = 1'b0;
  int          mdl_delay = 0;
  int          mdl_line[$];
  logic [7:0]  exp_pix = '0;
  logic        exp_de = 1'b0;

  always @(posedge clk) begin
    int n, bits, wi;
    if (s_we) mdl_mem[{~mdl_bank, s_adr}] = s_dat;
    exp_pix = '0;
    exp_de  = 1'b0;
    if (reset) begin
      mdl_bank = 1'b0;
      mdl_hs_q = 1'b0;
      mdl_delay = 0;
      mdl_line.delete();
    end else begin
      if (vsync) begin
        mdl_line.delete();
        mdl_delay = 0;
      end else if (hsync && !mdl_hs_q) begin
        mdl_bank = ~mdl_bank;
        mdl_line.delete();
        mdl_delay = 0;
        n = (line_len > 256) ? 256 : int'(line_len);
        if (den && n != 0) begin
          bits = 1 << bpp;
          for (int i = 0; i < n; i++) begin
            wi = int'(mdl_mem[{mdl_bank, i[7:0]}]);
            for (int k = 0; k < 16 / bits; k++)
              mdl_line.push_back((wi >> (16 - bits * (k + 1))) & ((1 << bits) - 1));
          end
          mdl_delay = 3;
        end
      end else if (mdl_delay > 0) begin
        mdl_delay--;
      end else if (mdl_line.size() > 0 && hden) begin
        exp_pix = 8'(mdl_line.pop_front());
        exp_de  = 1'b1;
      end
      mdl_hs_q = hsync;
    end
  end

  // Every-cycle comparison against the model, plus capture of emitted pixels.
  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      checks++;
      if (pixel !== exp_pix || de !== exp_de) begin
        errors++;
        $display("FAIL cycle %0d: pixel_o=%h de_o=%b, model wants pixel=%h de=%b",
                 cyc, pixel, de, exp_pix, exp_de);
      end
      if (de === 1'b1) begin
        cap.push_back(int'(pixel));
        cap_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  function automatic int cap_at(input int i);
    return (i < cap.size()) ? cap[i] : -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] adr, input logic [15:0] dat);
    s_we = 1'b1; s_adr = adr; s_dat = dat;
    tick(1);
    s_we = 1'b0;
  endtask

  task automatic start_line(input int len, input int b, input logic d);
    line_len = 9'(len); bpp = 2'(b); den = d;
    hden = 1'b0; hsync = 1'b1;
    tick(1);
    cap.delete(); cap_cyc.delete();
    hsync = 1'b0; hden = 1'b1;
  endtask

  task automatic end_line(input int n);
    tick(n);
    hden = 1'b0;
    tick(2);
  endtask

  int exp1 [32] = '{1,0,1,0,0,1,0,1,1,1,1,1,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1};
  int exp2 [6]  = '{'h12,'h34,'h56,'h78,'h9A,'hBC};
  int exp3 [8]  = '{2,2,1,1,2,2,1,1};

  initial begin
    int cnt;
    tick(1);
    chk_en = 1'b1;
    tick(2);
    check("reset_de", int'(de), 0);
    check("reset_pixel", int'(pixel), 0);
    reset = 1'b0;
    tick(2);

    // 1bpp, two words, displayed from bank 1.
    write_word(8'd0, 16'hA5F0);
    write_word(8'd1, 16'h0001);
    start_line(2, 0, 1'b1);
    end_line(40);
    check("1bpp_count", cap.size(), 32);
    for (int i = 0; i < 32; i++) check($sformatf("1bpp_px%0d", i), cap_at(i), exp1[i]);

    // 8bpp, three words, bank 0, no gaps across word boundaries.
    write_word(8'd0, 16'h1234);
    write_word(8'd1, 16'h5678);
    write_word(8'd2, 16'h9ABC);
    start_line(3, 3, 1'b1);
    end_line(12);
    check("8bpp_count", cap.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("8bpp_px%0d", i), cap_at(i), exp2[i]);
    if (cap_cyc.size() == 6) check("8bpp_contiguous", cap_cyc[5] - cap_cyc[0], 5);
    else check("8bpp_contiguous", cap_cyc.size(), 6);

    // Ping-pong: bank 1 all ones displays while bank 0 is filled with A5A5.
    for (int i = 0; i < 4; i++) write_word(8'(i), 16'hFFFF);
    start_line(4, 1, 1'b1);
    for (int i = 0; i < 4; i++) write_word(8'(i), 16'hA5A5);
    end_line(36);
    cnt = 0;
    foreach (cap[i]) if (cap[i] == 3) cnt++;
    check("pingpong_n_count", cap.size(), 32);
    check("pingpong_n_all3", cnt, 32);
    start_line(4, 1, 1'b1);
    end_line(40);
    check("pingpong_n1_count", cap.size(), 32);
    for (int i = 0; i < 8; i++) check($sformatf("pingpong_n1_px%0d", i), cap_at(i), exp3[i]);

    // Blank lines: display disabled, then zero length.
    start_line(2, 0, 1'b0);
    end_line(40);
    check("den0_blank", cap.size(), 0);
    start_line(0, 0, 1'b1);
    end_line(40);
    check("len0_blank", cap.size(), 0);

    // hsync mid-line abandons the all-ones line and restarts on the A5A5 bank.
    start_line(4, 1, 1'b1);
    tick(10);
    check("midline_pre_de", int'(de), 1);
    hsync = 1'b1;
    tick(1);
    cap.delete(); cap_cyc.delete();
    hsync = 1'b0;
    end_line(40);
    check("restart_count", cap.size(), 32);
    for (int i = 0; i < 4; i++) check($sformatf("restart_px%0d", i), cap_at(i), exp3[i]);

    // vsync mid-line forces outputs low.
    start_line(4, 1, 1'b1);
    tick(10);
    vsync = 1'b1;
    tick(1);
    check("vsync_de", int'(de), 0);
    check("vsync_pixel", int'(pixel), 0);
    tick(3);
    vsync = 1'b0;
    end_line(5);

    // Reset mid-line: outputs drop at once and read bank returns to 0.
    start_line(4, 1, 1'b1);
    tick(10);
    reset = 1'b1;
    tick(1);
    check("midreset_de", int'(de), 0);
    check("midreset_pixel", int'(pixel), 0);
    reset = 1'b0;
    hden = 1'b0;
    tick(2);
    write_word(8'd0, 16'h8001);
    start_line(1, 0, 1'b1);
    end_line(24);
    check("postreset_count", cap.size(), 16);
    check("postreset_px0", cap_at(0), 1);
    check("postreset_px2", cap_at(2), 0);
    check("postreset_px7", cap_at(7), 0);
    check("postreset_px15", cap_at(15), 1);

    // Length above 256 clamps to a full bank; read address wraps after the end.
    for (int i = 0; i < 256; i++) write_word(8'(i), {8'(i), ~8'(i)});
    start_line(300, 3, 1'b1);
    end_line(530);
    check("clamp_count", cap.size(), 512);
    check("clamp_px1", cap_at(1), 'hFF);
    check("clamp_px2", cap_at(2), 'h01);
    check("clamp_px510", cap_at(510), 'hFF);
    check("clamp_px511", cap_at(511), 'h00);

    tick(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
